// File: rtl/tft_pkg.sv
// Shared types and default 640x480@60 timing for the TFT timing generator.
package tft_pkg;

    localparam int unsigned PIX_W = 24;
    localparam int unsigned CNT_W = 11;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam logic [PIX_W-1:0] DEF_UNDERFLOW_COLOR = 24'hFF00FF;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } tft_state_e;

    function automatic int unsigned raster_total(input int unsigned active,
                                                 input int unsigned fp,
                                                 input int unsigned sync,
                                                 input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/tft_raster_counter.sv
// Horizontal/vertical raster counters with active, sync and frame-boundary decode.
module tft_raster_counter
    import tft_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    output logic active_o,
    output logic hsync_n_o,
    output logic vsync_n_o,
    output logic frame_start_o,
    output logic frame_end_o
);

    localparam int unsigned H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] HActive    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HSyncFirst = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HSyncLast  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] HLast      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] VActive    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VSyncFirst = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VSyncLast  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] VLast      = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             line_end;

    assign line_end = (hcnt_q == HLast);

    // Outside RUN the counters are forced to the origin so RUN always starts at (0,0).
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (!run_i) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (line_end) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + CNT_W'(1);
        end else begin
            hcnt_d = hcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign active_o      = run_i && (hcnt_q < HActive) && (vcnt_q < VActive);
    assign hsync_n_o     = !(run_i && (hcnt_q >= HSyncFirst) && (hcnt_q <= HSyncLast));
    assign vsync_n_o     = !(run_i && (vcnt_q >= VSyncFirst) && (vcnt_q <= VSyncLast));
    assign frame_start_o = run_i && (hcnt_q == '0) && (vcnt_q == '0);
    assign frame_end_o   = run_i && line_end && (vcnt_q == VLast);

endmodule

// File: rtl/tft_timing_gen.sv
// TFT video timing generator: raster FSM, pixel stream handshake, underflow fill
// and registered HSYNC/VSYNC/DE/RGB outputs.
module tft_timing_gen
    import tft_pkg::*;
#(
    parameter int unsigned       H_ACTIVE        = DEF_H_ACTIVE,
    parameter int unsigned       H_FP            = DEF_H_FP,
    parameter int unsigned       H_SYNC          = DEF_H_SYNC,
    parameter int unsigned       H_BP            = DEF_H_BP,
    parameter int unsigned       V_ACTIVE        = DEF_V_ACTIVE,
    parameter int unsigned       V_FP            = DEF_V_FP,
    parameter int unsigned       V_SYNC          = DEF_V_SYNC,
    parameter int unsigned       V_BP            = DEF_V_BP,
    parameter logic [PIX_W-1:0]  UNDERFLOW_COLOR = DEF_UNDERFLOW_COLOR
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic [PIX_W-1:0] PIX_DATA,
    input  logic             PIX_VALID,
    output logic             PIX_READY,
    output logic             FRAME_START,
    output logic             UNDERFLOW,
    input  logic             UNDERFLOW_CLR,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             DE,
    output logic [7:0]       RED,
    output logic [7:0]       GREEN,
    output logic [7:0]       BLUE
);

    tft_state_e       state_q;
    logic             run;
    logic             active;
    logic             hsync_n;
    logic             vsync_n;
    logic             frame_start;
    logic             frame_end;

    logic             hsync_q;
    logic             vsync_q;
    logic             de_q;
    logic [PIX_W-1:0] rgb_q;
    logic [PIX_W-1:0] rgb_d;
    logic             underflow_q;

    assign run = (state_q == StRun);

    tft_raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_raster (
        .clk_i         (Clk),
        .rst_ni        (Reset_n),
        .run_i         (run),
        .active_o      (active),
        .hsync_n_o     (hsync_n),
        .vsync_n_o     (vsync_n),
        .frame_start_o (frame_start),
        .frame_end_o   (frame_end)
    );

    // A disabled raster always finishes the current frame before idling.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (Enable) state_q <= StRun;
                StRun:   if (frame_end && !Enable) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // The raster never stalls: a missing pixel is replaced, not waited for.
    always_comb begin
        rgb_d = '0;
        if (active) begin
            rgb_d = PIX_VALID ? PIX_DATA : UNDERFLOW_COLOR;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hsync_q <= hsync_n;
            vsync_q <= vsync_n;
            de_q    <= active;
            rgb_q   <= rgb_d;
        end
    end

    // Set has priority so a clear cannot mask an underflow in the same cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            underflow_q <= 1'b0;
        end else if (active && !PIX_VALID) begin
            underflow_q <= 1'b1;
        end else if (UNDERFLOW_CLR) begin
            underflow_q <= 1'b0;
        end
    end

    assign PIX_READY   = active;
    assign FRAME_START = frame_start;
    assign UNDERFLOW   = underflow_q;
    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign DE          = de_q;
    assign RED         = rgb_q[23:16];
    assign GREEN       = rgb_q[15:8];
    assign BLUE        = rgb_q[7:0];

endmodule
